// File: rtl/pht_multiport_pkg.sv
// pht_multiport_pkg: default table geometry and FSM state type for the gshare PHT
`ifndef GSH_PHT_ENT_SEL
`define GSH_PHT_ENT_SEL 4
`endif
`ifndef GSH_PHT_ENT_NUM
`define GSH_PHT_ENT_NUM (1 << `GSH_PHT_ENT_SEL)
`endif
`ifndef GSH_PHT_DATA_WIDTH
`define GSH_PHT_DATA_WIDTH 2
`endif
package pht_multiport_pkg;
  localparam int PHT_ENT_SEL = `GSH_PHT_ENT_SEL;
  localparam int PHT_ENT_NUM = `GSH_PHT_ENT_NUM;
  localparam int PHT_CTR_W   = `GSH_PHT_DATA_WIDTH;
  typedef enum logic {ST_INIT, ST_RUN} pht_state_e;
endpackage

// File: rtl/pht_multiport_if.sv
// pht_multiport_if: read/update/clear bus of the PHT
//   i_clr/o_busy          : re-init request, sweep in progress
//   i_rd_en/i_rd_addr     : NUM_RD packed read requests
//   o_rd_valid/o_rd_data  : per-port result one cycle later
//   i_upd_en/addr/taken   : resolved-branch commit
interface pht_multiport_if #(
  parameter int NUM_RD  = 2,
  parameter int ENT_SEL = 4,
  parameter int CTR_W   = 2
);
  logic                      i_clr;
  logic                      o_busy;
  logic [NUM_RD-1:0]         i_rd_en;
  logic [NUM_RD*ENT_SEL-1:0] i_rd_addr;
  logic [NUM_RD-1:0]         o_rd_valid;
  logic [NUM_RD*CTR_W-1:0]   o_rd_data;
  logic                      i_upd_en;
  logic [ENT_SEL-1:0]        i_upd_addr;
  logic                      i_upd_taken;
  modport master (
    output i_clr, i_rd_en, i_rd_addr, i_upd_en, i_upd_addr, i_upd_taken,
    input  o_busy, o_rd_valid, o_rd_data
  );
  modport slave (
    input  i_clr, i_rd_en, i_rd_addr, i_upd_en, i_upd_addr, i_upd_taken,
    output o_busy, o_rd_valid, o_rd_data
  );
endinterface

// File: rtl/pht_ctr_next.sv
// pht_ctr_next: saturating counter step
//   i_old   : current counter
//   i_taken : 1 = count up, 0 = count down
//   o_new   : next counter, clamped at 0 and all-ones
module pht_ctr_next #(
  parameter int CTR_W = 2
) (
  input  logic [CTR_W-1:0] i_old,
  input  logic             i_taken,
  output logic [CTR_W-1:0] o_new
);
  always_comb begin
    o_new = i_taken ? ((&i_old) ? i_old : i_old + CTR_W'(1))
                    : ((|i_old) ? i_old - CTR_W'(1) : i_old);
  end
endmodule

// File: rtl/pht_multiport.sv
// pht_multiport: gshare PHT with NUM_RD read ports and an internal RMW update pipe
//   clk, rst_n : clock, async active-low reset
//   bus        : pht_multiport_if slave (clear/busy, reads, updates)
module pht_multiport import pht_multiport_pkg::*; #(
  parameter int               NUM_RD   = 2,
  parameter int               ENT_SEL  = PHT_ENT_SEL,
  parameter int               CTR_W    = PHT_CTR_W,
  parameter logic [CTR_W-1:0] INIT_VAL = CTR_W'(1) << (CTR_W - 1)
) (
  input logic             clk,
  input logic             rst_n,
  pht_multiport_if.slave  bus
);
  localparam int DEPTH = 1 << ENT_SEL;
  pht_state_e         r_state;
  logic [ENT_SEL-1:0] r_ptr;
  logic               r_busy;
  logic               r_u1_v;
  logic               r_u1_taken;
  logic [ENT_SEL-1:0] r_u1_addr;
  logic [CTR_W-1:0]   r_u1_old;
  logic [CTR_W-1:0]   w_u1_new;
  logic [CTR_W-1:0]   w_u0_old;
  logic               w_acc;
  logic               w_u1_we;
  logic               w_sweep;
  logic               w_we;
  logic [ENT_SEL-1:0] w_waddr;
  logic [CTR_W-1:0]   w_wdata;
  logic [CTR_W-1:0]   r_mem [DEPTH];

  assign bus.o_busy = r_busy;
  assign w_sweep    = (r_state == ST_INIT);
  // an update arriving with i_clr is discarded, as is the one sitting in U1
  assign w_acc      = bus.i_upd_en & ~r_busy & ~bus.i_clr;
  assign w_u1_we    = r_u1_v & ~w_sweep & ~bus.i_clr;
  assign w_we       = w_sweep | w_u1_we;
  assign w_waddr    = w_sweep ? r_ptr : r_u1_addr;
  assign w_wdata    = w_sweep ? INIT_VAL : w_u1_new;
  // U1 writes at the end of this cycle, so a same-index U0 must see its result
  assign w_u0_old   = (r_u1_v && r_u1_addr == bus.i_upd_addr) ? w_u1_new : r_mem[bus.i_upd_addr];

  pht_ctr_next #(.CTR_W(CTR_W)) u_ctr_next (
    .i_old   (r_u1_old),
    .i_taken (r_u1_taken),
    .o_new   (w_u1_new)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_ptr      <= '0;
      r_busy     <= 1'b1;
      r_u1_v     <= 1'b0;
      r_u1_taken <= 1'b0;
      r_u1_addr  <= '0;
      r_u1_old   <= '0;
    end else begin
      r_u1_v <= w_acc;
      if (w_acc) begin
        r_u1_addr  <= bus.i_upd_addr;
        r_u1_taken <= bus.i_upd_taken;
        r_u1_old   <= w_u0_old;
      end
      if (bus.i_clr) begin
        r_state <= ST_INIT;
        r_ptr   <= '0;
        r_busy  <= 1'b1;
      end else if (w_sweep) begin
        r_ptr <= r_ptr + ENT_SEL'(1);
        if (&r_ptr) begin
          r_state <= ST_RUN;
          r_busy  <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    logic [ENT_SEL-1:0] w_addr;
    logic               w_req;
    logic               r_v;
    logic [CTR_W-1:0]   r_d;
    assign w_addr = bus.i_rd_addr[p*ENT_SEL +: ENT_SEL];
    assign w_req  = bus.i_rd_en[p] & ~r_busy;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_v <= 1'b0;
        r_d <= '0;
      end else begin
        r_v <= w_req;
        // write-first: a U1 commit to the same index this cycle wins over the array
        if (w_req) r_d <= (w_u1_we && r_u1_addr == w_addr) ? w_u1_new : r_mem[w_addr];
      end
    end
    assign bus.o_rd_valid[p]              = r_v;
    assign bus.o_rd_data[p*CTR_W +: CTR_W] = r_d;
  end
endmodule
